// File: rtl/candy_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : candy_muldiv
//  Description : Iterative multiply/divide unit for the candy core. Unsigned
//                and signed multiply (radix-2 shift-add) and unsigned and
//                signed divide (restoring shift-subtract), one bit per cycle,
//                using the core's start/annul/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module candy_muldiv #(
    parameter int WIDTH = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic               busy_o,
    output logic               ready_o,
    output logic               div_zero_o,
    output logic [WIDTH-1:0]   result_hi_o,
    output logic [WIDTH-1:0]   result_lo_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_one  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_count;
    logic                   r_is_div;
    logic                   r_neg_lo;   // product sign (MUL) or quotient sign (DIV)
    logic                   r_neg_hi;   // remainder sign (DIV only)
    logic [WIDTH-1:0]       r_opnd;     // multiplicand magnitude or divisor magnitude
    logic [2*WIDTH-1:0]     r_acc;      // MUL: {partial, multiplier}; DIV: {remainder, quotient}
    logic                   r_busy;
    logic                   r_ready;
    logic                   r_div_zero;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;

    logic                   w_a_neg;
    logic                   w_b_neg;
    logic [WIDTH-1:0]       w_a_mag;
    logic [WIDTH-1:0]       w_b_mag;
    logic [WIDTH:0]         w_mul_sum;
    logic [WIDTH:0]         w_div_shift;
    logic [WIDTH:0]         w_div_trial;
    logic [2*WIDTH-1:0]     w_step;
    logic [2*WIDTH-1:0]     w_mul_fix;
    logic [WIDTH-1:0]       w_q_fix;
    logic [WIDTH-1:0]       w_r_fix;
    logic [WIDTH-1:0]       w_fin_hi;
    logic [WIDTH-1:0]       w_fin_lo;

    // Operand sign detection and magnitude extraction (most-negative maps to 2^(W-1))
    always_comb begin
        w_a_neg = op_i[0] & opdata1_i[WIDTH-1];
        w_b_neg = op_i[0] & opdata2_i[WIDTH-1];
        w_a_mag = w_a_neg ? -opdata1_i : opdata1_i;
        w_b_mag = w_b_neg ? -opdata2_i : opdata2_i;
    end

    // One iteration of shift-add or restoring shift-subtract, plus final sign fix-up
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
        w_div_trial = w_div_shift - {1'b0, r_opnd};
        if (r_is_div) begin
            if (w_div_trial[WIDTH])
                w_step = {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            else
                w_step = {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end else begin
            w_step = {w_mul_sum, r_acc[WIDTH-1:1]};
        end
        w_mul_fix = r_neg_lo ? -w_step : w_step;
        w_q_fix   = r_neg_lo ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0];
        w_r_fix   = r_neg_hi ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];
        w_fin_hi  = r_is_div ? w_r_fix : w_mul_fix[2*WIDTH-1:WIDTH];
        w_fin_lo  = r_is_div ? w_q_fix : w_mul_fix[WIDTH-1:0];
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_is_div   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_opnd     <= '0;
            r_acc      <= '0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    if (start_i && !annul_i) begin
                        r_busy <= 1'b1;
                        if (op_i[1] && (opdata2_i == '0)) begin
                            // Divide by zero completes immediately with raw dividend as remainder
                            r_state    <= S_DONE;
                            r_ready    <= 1'b1;
                            r_div_zero <= 1'b1;
                            r_lo       <= '1;
                            r_hi       <= opdata1_i;
                        end else begin
                            r_state    <= S_RUN;
                            r_div_zero <= 1'b0;
                            r_count    <= '0;
                            r_is_div   <= op_i[1];
                            r_neg_lo   <= w_a_neg ^ w_b_neg;
                            r_neg_hi   <= op_i[1] & w_a_neg;
                            r_opnd     <= op_i[1] ? w_b_mag : w_a_mag;
                            r_acc      <= {{WIDTH{1'b0}}, (op_i[1] ? w_a_mag : w_b_mag)};
                        end
                    end
                end
                S_RUN: begin
                    if (annul_i) begin
                        // Abort leaves previous results and flag untouched
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc   <= w_step;
                        r_count <= r_count + c_one;
                        if (r_count == c_last) begin
                            r_hi    <= w_fin_hi;
                            r_lo    <= w_fin_lo;
                            r_ready <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign ready_o     = r_ready;
    assign div_zero_o  = r_div_zero;
    assign result_hi_o = r_hi;
    assign result_lo_o = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_candy_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_candy_muldiv
//  Description : Directed self-checking bench for candy_muldiv (WIDTH=24).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_candy_muldiv;

    localparam int WIDTH = 24;

    logic             clk;
    logic             rst;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] opdata1_i;
    logic [WIDTH-1:0] opdata2_i;
    logic             start_i;
    logic             annul_i;
    logic             busy_o;
    logic             ready_o;
    logic             div_zero_o;
    logic [WIDTH-1:0] result_hi_o;
    logic [WIDTH-1:0] result_lo_o;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    logic busy_acc;
    logic dz_acc;
    int rdy_seen;

    candy_muldiv #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .op_i        (op_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .busy_o      (busy_o),
        .ready_o     (ready_o),
        .div_zero_o  (div_zero_o),
        .result_hi_o (result_hi_o),
        .result_lo_o (result_lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start an op at accept edge k; lat = edges after k until ready_o seen (100 = timeout)
    task automatic do_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, output int l,
                         output logic busy_k, output logic dz_k);
        op_i = op; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        opdata1_i = '1; opdata2_i = '1; op_i = 2'b00;
        busy_k = busy_o;
        dz_k = div_zero_o;
        l = 0;
        while (!ready_o && l < 100) begin
            tick();
            l++;
        end
    endtask

    // Ready must be a single-cycle pulse and the unit must go idle after it
    task automatic chk_end(input string tag);
        chk({tag, "_busy_done"}, {31'd0, busy_o}, 32'd1);
        tick();
        chk({tag, "_ready_pulse"}, {31'd0, ready_o}, 32'd0);
        chk({tag, "_busy_idle"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; op_i = 2'b00; opdata1_i = '0; opdata2_i = '0;
        start_i = 1'b0; annul_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy",  {31'd0, busy_o}, 32'd0);
        chk("rst_ready", {31'd0, ready_o}, 32'd0);
        chk("rst_dz",    {31'd0, div_zero_o}, 32'd0);
        chk("rst_hi",    {8'd0, result_hi_o}, 32'd0);
        chk("rst_lo",    {8'd0, result_lo_o}, 32'd0);
        tick();

        // 1: MULU max*max
        do_op(2'b00, 24'hFFFFFF, 24'hFFFFFF, lat, busy_acc, dz_acc);
        chk("mulu_lat",  lat, 32'd24);
        chk("mulu_busy_k1", {31'd0, busy_acc}, 32'd1);
        chk("mulu_hi",   {8'd0, result_hi_o}, 32'hFFFFFE);
        chk("mulu_lo",   {8'd0, result_lo_o}, 32'h000001);
        chk_end("mulu");

        // 2: MULS
        do_op(2'b01, 24'hFFFFFD, 24'h000005, lat, busy_acc, dz_acc);
        chk("muls_neg_lat", lat, 32'd24);
        chk("muls_neg_hi", {8'd0, result_hi_o}, 32'hFFFFFF);
        chk("muls_neg_lo", {8'd0, result_lo_o}, 32'hFFFFF1);
        chk_end("muls_neg");
        do_op(2'b01, 24'h800000, 24'h800000, lat, busy_acc, dz_acc);
        chk("muls_min_hi", {8'd0, result_hi_o}, 32'h400000);
        chk("muls_min_lo", {8'd0, result_lo_o}, 32'h000000);
        chk_end("muls_min");

        // 3: divides
        do_op(2'b10, 24'd100, 24'd7, lat, busy_acc, dz_acc);
        chk("divu_lat", lat, 32'd24);
        chk("divu_lo", {8'd0, result_lo_o}, 32'd14);
        chk("divu_hi", {8'd0, result_hi_o}, 32'd2);
        chk("divu_dz", {31'd0, div_zero_o}, 32'd0);
        chk_end("divu");
        do_op(2'b11, 24'hFFFFF9, 24'd2, lat, busy_acc, dz_acc);
        chk("divs_m7_2_lo", {8'd0, result_lo_o}, 32'hFFFFFD);
        chk("divs_m7_2_hi", {8'd0, result_hi_o}, 32'hFFFFFF);
        tick();
        do_op(2'b11, 24'd7, 24'hFFFFFE, lat, busy_acc, dz_acc);
        chk("divs_7_m2_lo", {8'd0, result_lo_o}, 32'hFFFFFD);
        chk("divs_7_m2_hi", {8'd0, result_hi_o}, 32'h000001);
        tick();
        do_op(2'b11, 24'h800000, 24'hFFFFFF, lat, busy_acc, dz_acc);
        chk("divs_ovf_lo", {8'd0, result_lo_o}, 32'h800000);
        chk("divs_ovf_hi", {8'd0, result_hi_o}, 32'h000000);
        chk("divs_ovf_dz", {31'd0, div_zero_o}, 32'd0);
        tick();

        // 4: divide by zero, then a multiply clears the flag at accept
        do_op(2'b10, 24'd5, 24'd0, lat, busy_acc, dz_acc);
        chk("dz_lat", lat, 32'd0);
        chk("dz_lo",  {8'd0, result_lo_o}, 32'hFFFFFF);
        chk("dz_hi",  {8'd0, result_hi_o}, 32'd5);
        chk("dz_flag", {31'd0, div_zero_o}, 32'd1);
        chk_end("dz");
        do_op(2'b00, 24'd2, 24'd3, lat, busy_acc, dz_acc);
        chk("dz_clear_at_accept", {31'd0, dz_acc}, 32'd0);
        chk("mul23_lo", {8'd0, result_lo_o}, 32'd6);
        chk("mul23_hi", {8'd0, result_hi_o}, 32'd0);
        tick();

        // 5: annul at counter=10, with a start pulse mid-operation
        op_i = 2'b10; opdata1_i = 24'd1000; opdata2_i = 24'd3; start_i = 1'b1;
        tick();
        opdata1_i = 24'd4; opdata2_i = 24'd2;
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) begin
                start_i = 1'b1;
                op_i = 2'b00;
            end else begin
                start_i = 1'b0;
            end
            tick();
        end
        start_i = 1'b0;
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0;
        chk("annul_busy", {31'd0, busy_o}, 32'd0);
        rdy_seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (ready_o) rdy_seen++;
            tick();
        end
        chk("annul_no_ready", rdy_seen, 32'd0);
        chk("annul_hi_kept", {8'd0, result_hi_o}, 32'd0);
        chk("annul_lo_kept", {8'd0, result_lo_o}, 32'd6);

        // start together with annul in IDLE is rejected
        op_i = 2'b00; opdata1_i = 24'd9; opdata2_i = 24'd9;
        start_i = 1'b1; annul_i = 1'b1;
        tick();
        start_i = 1'b0; annul_i = 1'b0;
        chk("start_annul_rejected", {31'd0, busy_o}, 32'd0);
        tick();

        do_op(2'b10, 24'd1000, 24'd3, lat, busy_acc, dz_acc);
        chk("fresh_lat", lat, 32'd24);
        chk("fresh_lo", {8'd0, result_lo_o}, 32'd333);
        chk("fresh_hi", {8'd0, result_hi_o}, 32'd1);
        tick();

        // 6: reset mid-MULS at counter=5
        op_i = 2'b01; opdata1_i = 24'hFFFFFD; opdata2_i = 24'd5; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy",  {31'd0, busy_o}, 32'd0);
        chk("mrst_ready", {31'd0, ready_o}, 32'd0);
        chk("mrst_dz",    {31'd0, div_zero_o}, 32'd0);
        chk("mrst_hi",    {8'd0, result_hi_o}, 32'd0);
        chk("mrst_lo",    {8'd0, result_lo_o}, 32'd0);
        do_op(2'b10, 24'd9, 24'd3, lat, busy_acc, dz_acc);
        chk("post_rst_lat", lat, 32'd24);
        chk("post_rst_lo", {8'd0, result_lo_o}, 32'd3);
        chk("post_rst_hi", {8'd0, result_hi_o}, 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/candy_muldiv.md
Name: candy_muldiv

Overview:
Parametrised iterative multiply/divide unit for the candy core. It replaces the fixed 24-bit divider with one engine of configurable width that runs unsigned and signed multiply, and unsigned and signed divide. It processes one bit per cycle and uses the same start/annul/ready handshake the core already drives. It sits beside candy_alu and is driven by the execute stage for multi-cycle ops.

Parameters:
WIDTH, 24, operand width in bits (>=4). The result is 2*WIDTH bits, split into hi and lo words.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  reset; synchronous, active-high
op_i  input  2  operation: 00 MULU, 01 MULS, 10 DIVU, 11 DIVS
opdata1_i  input  WIDTH  multiplicand / dividend
opdata2_i  input  WIDTH  multiplier / divisor
start_i  input  1  request; sampled only in IDLE
annul_i  input  1  abort the current operation
busy_o  output  1  high in RUN and DONE
ready_o  output  1  one-cycle pulse: results valid
div_zero_o  output  1  last completed divide had divisor 0
result_hi_o  output  WIDTH  MUL: product[2W-1:W]; DIV: remainder
result_lo_o  output  WIDTH  MUL: product[W-1:0]; DIV: quotient

Behaviour:
- Reset: rst=1 at an edge forces IDLE and clears counter, internal registers, busy_o, ready_o, div_zero_o, result_hi_o and result_lo_o to 0. This applies in any state, including mid-operation. rst has priority over all other inputs.
- FSM states: IDLE, RUN, DONE.
- IDLE, start_i=1, annul_i=0:
  - Latch op_i and the operand magnitudes. For signed ops, take the absolute value in WIDTH bits and record the result sign and the remainder sign.
  - Clear the counter, clear div_zero_o, go to RUN.
  - Exception: a DIV op with opdata2_i==0 goes straight to DONE with result_lo=all ones, result_hi=opdata1_i (raw), div_zero_o=1.
- RUN: one iteration per edge; the counter increments 0..WIDTH-1.
  - MUL: radix-2 shift-add over a 2W accumulator.
  - DIV: restoring shift-subtract; trial subtract is W+1 bits wide.
  - On the edge of iteration WIDTH-1, apply sign correction (two's complement negate, 2W bits for MUL, W bits for each DIV word), register result_hi_o/result_lo_o, go to DONE.
- DONE: ready_o=1 for exactly this one cycle. Next edge goes to IDLE.
- Latency: the start is accepted at edge k. ready_o is high during the cycle after edge k+WIDTH. For divide-by-zero, ready_o is high during the cycle after edge k.
- Results and div_zero_o hold until the next accepted start. They do not change on annul.
- Signed rules:
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign of dividend.
  - DIVS most-negative / -1 gives quotient = most-negative (wraps), remainder 0, no flag.
  - MULS gives the exact 2W two's-complement product.
- annul_i=1 in RUN: next edge goes to IDLE. No ready pulse; outputs are unchanged.
- annul_i=1 in DONE: ignored. The pulse completes.
- annul_i=1 with start_i in IDLE: the start is rejected.
- start_i while busy_o=1 is ignored. It is not queued.
- Operand inputs are sampled only at the accept edge and may change afterwards.

Test Plan:
1. WIDTH=24, MULU 0xFFFFFF*0xFFFFFF -> ready_o one cycle after edge k+24; hi=0xFFFFFE, lo=0x000001; busy_o high from k+1 until the DONE cycle ends.
2. MULS -3*5 (0xFFFFFD, 0x000005) -> hi=0xFFFFFF, lo=0xFFFFF1. MULS 0x800000*0x800000 -> hi=0x400000, lo=0x000000.
3. DIVU 100/7 -> lo=14, hi=2. DIVS -7/2 -> lo=0xFFFFFD, hi=0xFFFFFF. DIVS 7/-2 -> lo=0xFFFFFD, hi=0x000001. DIVS 0x800000/0xFFFFFF -> lo=0x800000, hi=0.
4. DIVU 5/0 -> ready_o in the cycle after the accept edge; lo=0xFFFFFF, hi=5, div_zero_o=1. A following MULU 2*3 clears div_zero_o at accept and yields lo=6.
5. Annul at counter=10 of a DIVU -> IDLE next edge, no ready pulse, previous results unchanged. A start_i pulse mid-op is ignored. A fresh start afterwards completes with correct latency.
6. rst=1 at counter=5 of a MULS -> after that edge all outputs are 0 and the state is IDLE. An immediate new DIVU 9/3 gives lo=3, hi=0.
